// File: rtl/pmu_pkg.sv
// Shared PMU constants and types. The event shaper and noc_pmu both use these,
// so they must agree on lane count and field widths.
package pmu_pkg;

    localparam int PMU_EVENT_COUNT = 23;
    localparam int PMU_INC_WIDTH   = 2;
    localparam int PMU_PEND_WIDTH  = 4;

    typedef logic [PMU_INC_WIDTH-1:0]  pmu_inc_t;
    typedef logic [PMU_PEND_WIDTH-1:0] pmu_pend_t;

endpackage

// File: rtl/pmu_event_lane.sv
// One event lane: buffers multi-bit increments in a saturating pending counter
// and emits at most one registered pulse per cycle.
module pmu_event_lane
    import pmu_pkg::*;
#(
    parameter int INC_WIDTH  = PMU_INC_WIDTH,
    parameter int PEND_WIDTH = PMU_PEND_WIDTH
) (
    input  logic                 counter_clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic                 edge_mode_i,
    output logic                 pulse_o,
    output logic                 overflow_o,
    output logic                 pend_nz_o
);

    localparam int SUM_W = PEND_WIDTH + 1;
    localparam logic [SUM_W-1:0] PEND_MAX = {1'b0, {PEND_WIDTH{1'b1}}};

    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  prev_q, prev_d;
    logic                  ovf_q, ovf_d;
    logic                  pulse_q, pulse_d;

    logic                  active;
    logic                  fire;
    logic [SUM_W-1:0]      eff;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      rem;

    always_comb begin
        active = |inc_i;
        eff    = '0;
        if (enable_i) begin
            eff = edge_mode_i ? SUM_W'(active && !prev_q) : SUM_W'(inc_i);
        end
        // One extra bit of headroom so saturation clamps instead of wrapping.
        sum  = {1'b0, pend_q} + eff;
        fire = |sum;
        rem  = sum - SUM_W'(fire);

        pend_d  = pend_q;
        prev_d  = active;
        ovf_d   = ovf_q;
        pulse_d = fire;
        if (clear_i) begin
            pend_d  = '0;
            prev_d  = 1'b0;
            ovf_d   = 1'b0;
            pulse_d = 1'b0;
        end else if (rem > PEND_MAX) begin
            pend_d = PEND_MAX[PEND_WIDTH-1:0];
            ovf_d  = 1'b1;
        end else begin
            pend_d = rem[PEND_WIDTH-1:0];
        end
    end

    always_ff @(posedge counter_clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            prev_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o    = pulse_q;
    assign overflow_o = ovf_q;
    assign pend_nz_o  = |pend_q;

endmodule

// File: rtl/pmu_event_shaper.sv
// Per-tile PMU event shaper: turns multi-bit per-cycle event increments into
// 1-bit count pulses, one independent lane per event.
module pmu_event_shaper
    import pmu_pkg::*;
#(
    parameter int EVENT_SIGNAL_COUNT = PMU_EVENT_COUNT,
    parameter int INC_WIDTH          = PMU_INC_WIDTH,
    parameter int PEND_WIDTH         = PMU_PEND_WIDTH
) (
    input  logic                                         counter_clk,
    input  logic                                         rst,
    input  logic                                         enable_i,
    input  logic                                         clear_i,
    input  logic [EVENT_SIGNAL_COUNT-1:0][INC_WIDTH-1:0] event_inc_i,
    input  logic [EVENT_SIGNAL_COUNT-1:0]                edge_mode_i,
    output logic [EVENT_SIGNAL_COUNT-1:0]                pmu_sig_o,
    output logic [EVENT_SIGNAL_COUNT-1:0]                overflow_o,
    output logic                                         busy_o
);

    logic [EVENT_SIGNAL_COUNT-1:0] pend_nz;

    for (genvar g = 0; g < EVENT_SIGNAL_COUNT; g++) begin : g_lane
        pmu_event_lane #(
            .INC_WIDTH  (INC_WIDTH),
            .PEND_WIDTH (PEND_WIDTH)
        ) u_lane (
            .counter_clk (counter_clk),
            .rst         (rst),
            .enable_i    (enable_i),
            .clear_i     (clear_i),
            .inc_i       (event_inc_i[g]),
            .edge_mode_i (edge_mode_i[g]),
            .pulse_o     (pmu_sig_o[g]),
            .overflow_o  (overflow_o[g]),
            .pend_nz_o   (pend_nz[g])
        );
    end

    // Pending registers only, so busy_o has no combinational input path.
    assign busy_o = |pend_nz;

endmodule

// File: tb/tb_pmu_event_shaper.sv
// Bench for pmu_event_shaper: lane-0 vector table, saturation and random
// sequences, with a per-cycle expected-output queue for all lanes.
module tb_pmu_event_shaper;

    localparam int N    = 23;
    localparam int IW   = 2;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic                  counter_clk = 1'b0;
    logic                  rst;
    logic                  enable_i;
    logic                  clear_i;
    logic [N-1:0][IW-1:0]  event_inc_i;
    logic [N-1:0]          edge_mode_i;
    logic [N-1:0]          pmu_sig_o;
    logic [N-1:0]          overflow_o;
    logic                  busy_o;

    pmu_event_shaper #(
        .EVENT_SIGNAL_COUNT (N),
        .INC_WIDTH          (IW),
        .PEND_WIDTH         (PW)
    ) dut (
        .counter_clk (counter_clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .event_inc_i (event_inc_i),
        .edge_mode_i (edge_mode_i),
        .pmu_sig_o   (pmu_sig_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    always #5 counter_clk = ~counter_clk;

    typedef struct {
        logic [N-1:0] sig;
        logic [N-1:0] ovf;
        logic         busy;
    } exp_t;

    typedef struct {
        logic [1:0] inc;
        logic       en;
        logic       clr;
        logic       edg;
        logic       sig;
        logic       busy;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mp[N];
    bit mprev[N];
    bit mov[N];
    int eff_sum[N];
    int pulse_cnt[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour for one cycle, pushed as the expectation for the next edge.
    task automatic model_step();
        exp_t e;
        e.sig  = '0;
        e.ovf  = '0;
        e.busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit a;
            int eff, sum, fire, nxt;
            a = (event_inc_i[i] != 0);
            if (clear_i) begin
                mp[i]    = 0;
                mprev[i] = 0;
                mov[i]   = 0;
            end else begin
                if (!enable_i)          eff = 0;
                else if (edge_mode_i[i]) eff = (a && !mprev[i]) ? 1 : 0;
                else                    eff = int'(event_inc_i[i]);
                sum  = mp[i] + eff;
                fire = (sum != 0) ? 1 : 0;
                nxt  = sum - fire;
                if (nxt > PMAX) begin
                    nxt    = PMAX;
                    mov[i] = 1;
                end
                mp[i]      = nxt;
                mprev[i]   = a;
                e.sig[i]   = fire[0];
                eff_sum[i] += eff;
            end
            e.ovf[i] = mov[i];
            if (mp[i] != 0) e.busy = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        if (pmu_sig_o !== e.sig || overflow_o !== e.ovf || busy_o !== e.busy) begin
            n_bad++;
            $display("FAIL sb_cycle: got sig=%h ovf=%h busy=%b expected sig=%h ovf=%h busy=%b",
                     pmu_sig_o, overflow_o, busy_o, e.sig, e.ovf, e.busy);
        end
        for (int i = 0; i < N; i++) pulse_cnt[i] += int'(pmu_sig_o[i]);
    endtask

    task automatic tick();
        model_step();
        @(posedge counter_clk);
        #1;
        check_out();
    endtask

    task automatic add(input logic [1:0] inc, input logic en, input logic clr, input logic edg,
                       input logic sig, input logic busy, input logic ovf);
        vec_t v;
        v.inc = inc; v.en = en; v.clr = clr; v.edg = edg;
        v.sig = sig; v.busy = busy; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        event_inc_i = '0;
        edge_mode_i = '0;
        enable_i    = 1'b1;
        clear_i     = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (busy_o && k < 40) begin
            tick();
            k++;
        end
        check({name, "_drain_timeout"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        // lane 0 vectors: inc, en, clr, edge, expected sig, busy, ovf
        add(3,1,0,0, 1,1,0); add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,0,0);
        add(3,1,0,0, 1,1,0); add(3,0,0,0, 1,1,0); add(3,0,0,0, 1,0,0); add(3,0,0,0, 0,0,0);
        add(1,1,0,0, 1,0,0); add(0,1,0,0, 0,0,0);
        for (int k = 0; k < 7; k++) add(3,1,0,0, 1,1,0);
        add(3,1,0,0, 1,1,1); add(3,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0);
        for (int k = 0; k < 3; k++) add(3,1,0,0, 1,1,0);
        add(2,1,0,0, 1,1,0); add(3,1,1,0, 0,0,0); add(0,1,0,0, 0,0,0);
        add(2,1,0,1, 1,0,0);
        for (int k = 0; k < 4; k++) add(2,1,0,1, 0,0,0);
        add(0,1,0,1, 0,0,0); add(1,1,0,1, 1,0,0); add(0,1,0,1, 0,0,0);
        add(1,0,0,1, 0,0,0); add(1,1,0,1, 0,0,0); add(0,1,0,1, 0,0,0);
        add(3,1,0,0, 1,1,0); add(0,1,0,1, 1,1,0); add(0,1,0,1, 1,0,0); add(0,1,0,1, 0,0,0);

        for (int i = 0; i < N; i++) begin
            mp[i] = 0; mprev[i] = 0; mov[i] = 0; eff_sum[i] = 0; pulse_cnt[i] = 0;
        end

        // Reset held with full increments on every lane
        rst         = 1'b0;
        enable_i    = 1'b1;
        clear_i     = 1'b0;
        edge_mode_i = '0;
        for (int i = 0; i < N; i++) event_inc_i[i] = 2'd3;
        repeat (3) @(posedge counter_clk);
        #1;
        check("rst_sig", 32'(pmu_sig_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Lane 0 table
        foreach (tbl[r]) begin
            event_inc_i    = '0;
            event_inc_i[0] = tbl[r].inc;
            edge_mode_i    = '0;
            edge_mode_i[0] = tbl[r].edg;
            enable_i       = tbl[r].en;
            clear_i        = tbl[r].clr;
            tick();
            check($sformatf("tbl%0d_sig", r), 32'(pmu_sig_o[0]), 32'(tbl[r].sig));
            check($sformatf("tbl%0d_busy", r), 32'(busy_o), 32'(tbl[r].busy));
            check($sformatf("tbl%0d_ovf", r), 32'(overflow_o[0]), 32'(tbl[r].ovf));
        end
        idle_inputs();
        tick();

        // Saturation on lane 1: 30 offered, 25 delivered
        pulse_cnt[1] = 0;
        for (int k = 0; k < 10; k++) begin
            idle_inputs();
            event_inc_i[1] = 2'd3;
            tick();
        end
        idle_inputs();
        check("sat_ovf1", 32'(overflow_o[1]), 32'd1);
        check("sat_ovf_other", 32'(overflow_o & ~(N'(1) << 1)), 32'd0);
        drain("sat");
        tick();
        check("sat_pulses", 32'(pulse_cnt[1]), 32'd25);
        check("sat_ovf_sticky", 32'(overflow_o[1]), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("sat_ovf_cleared", 32'(overflow_o), 32'd0);

        // Random independence run, light enough to never saturate
        for (int i = 0; i < N; i++) begin
            eff_sum[i]   = 0;
            pulse_cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) edge_mode_i[i] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                event_inc_i[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            enable_i = ($urandom_range(0, 9) != 0);
            tick();
        end
        idle_inputs();
        tick();
        drain("rand");
        tick();
        for (int i = 0; i < N; i++)
            check($sformatf("rand_lane%0d_count", i), 32'(pulse_cnt[i]), 32'(eff_sum[i]));
        check("rand_no_ovf", 32'(overflow_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
